fetch_pc_pipe: RTL and testbench

//  PC generator and prediction-metadata pipeline wrapped around the BTB. Holds the fetch PC (stage 1),

---
 rtl/fetch_pc_pipe_pkg.sv | 20 ++
 rtl/fetch_pc_pipe_if.sv | 35 +++
 rtl/fetch_pc_pipe_pred_stage_reg.sv | 31 +++
 rtl/fetch_pc_pipe.sv | 135 +++++++++++++
 tb/tb_fetch_pc_pipe.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_pipe_pkg.sv
// Shared types for the fetch PC pipeline: FSM state encodings, the per-stage
// prediction record and the default boot address.
package fetch_pc_pipe_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic        is_branch;
    logic        valid;
  } pred_stage_t;

endpackage

// File: rtl/fetch_pc_pipe_if.sv
// Fetch/BTB/decoder handshake bundle; master drives stalls and BTB results,
// slave (the PC pipeline) returns PCs, valids, kill and perf counters.
interface fetch_pc_pipe_if #(
  parameter int CNT_W = 32
);
  logic             memory_stall;
  logic             hazard_stall;
  logic             is_branch_2;
  logic [31:0]      btb_branchPC;
  logic             btb_flush;
  logic             btb_taken;
  logic [31:0]      PC_1;
  logic             fetch_valid;
  logic [31:0]      PC_2;
  logic [31:0]      PC_3;
  logic             valid_2;
  logic             valid_3;
  logic             prev_taken_3;
  logic             is_branch_3;
  logic             kill_2;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output memory_stall, hazard_stall, is_branch_2, btb_branchPC, btb_flush, btb_taken,
    input  PC_1, fetch_valid, PC_2, PC_3, valid_2, valid_3, prev_taken_3, is_branch_3,
    input  kill_2, branch_cnt, mispred_cnt
  );

  modport slave (
    input  memory_stall, hazard_stall, is_branch_2, btb_branchPC, btb_flush, btb_taken,
    output PC_1, fetch_valid, PC_2, PC_3, valid_2, valid_3, prev_taken_3, is_branch_3,
    output kill_2, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/fetch_pc_pipe_pred_stage_reg.sv
// One pipeline stage of {PC, pred_taken, is_branch, valid}; hold beats kill
// beats load, and kill only drops valid so the PC stays observable.
module pred_stage_reg
  import fetch_pc_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_i,
  input  logic        kill_i,
  input  logic        load_i,
  input  pred_stage_t d_i,
  output pred_stage_t q_o
);

  pred_stage_t stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (!hold_i) begin
      if (kill_i) begin
        stage_q.valid <= 1'b0;
      end else if (load_i) begin
        stage_q <= d_i;
      end
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/fetch_pc_pipe.sv
// Fetch PC generator plus ID/EX prediction pipeline around the BTB, with
// stall, redirect and stall-pending redirect handling. Optional: PC_PERF_CNT_EN.
module fetch_pc_pipe
  import fetch_pc_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_pc_pipe_if.slave bus
);

  fetch_state_e state_q;
  logic [31:0]  pc1_q;
  logic [31:0]  redirect_q;
  logic         fetch_valid_q;

  wire run      = (state_q == RUN);
  wire pend     = (state_q == PEND);
  wire ms       = bus.memory_stall;
  wire fl       = bus.btb_flush;
  wire hz       = bus.hazard_stall;

  // A redirect arriving during a memory stall is parked; later flushes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc1_q         <= RESET_PC;
      redirect_q    <= 32'h0;
      fetch_valid_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
        end
        RUN: begin
          if (ms && fl) begin
            redirect_q    <= bus.btb_branchPC;
            state_q       <= PEND;
            fetch_valid_q <= 1'b0;
          end else if (!ms && (fl || !hz)) begin
            pc1_q <= bus.btb_branchPC;
          end
        end
        PEND: begin
          if (!ms) begin
            pc1_q         <= redirect_q;
            state_q       <= RUN;
            fetch_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= BOOT;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  pred_stage_t s2_d, s2_q, s3_d, s3_q;

  // Stage 2 seeds is_branch=1; the decoder flag qualifies it on entry to stage 3.
  assign s2_d = '{pc: pc1_q, pred_taken: bus.btb_taken, is_branch: 1'b1, valid: 1'b1};
  assign s3_d = '{pc: s2_q.pc, pred_taken: s2_q.pred_taken,
                  is_branch: bus.is_branch_2 & s2_q.is_branch, valid: s2_q.valid};

  wire advance = run && !fl && !hz;

  pred_stage_reg u_stage2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i (ms),
    .kill_i ((run && fl) || pend),
    .load_i (advance),
    .d_i    (s2_d),
    .q_o    (s2_q)
  );

  pred_stage_reg u_stage3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i (ms),
    .kill_i ((run && (fl || hz)) || pend),
    .load_i (advance),
    .d_i    (s3_d),
    .q_o    (s3_q)
  );

  assign bus.PC_1         = pc1_q;
  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.PC_2         = s2_q.pc;
  assign bus.valid_2      = s2_q.valid;
  assign bus.PC_3         = s3_q.pc;
  assign bus.valid_3      = s3_q.valid;
  assign bus.prev_taken_3 = s3_q.pred_taken & s3_q.valid;
  assign bus.is_branch_3  = s3_q.is_branch & s3_q.valid;
  assign bus.kill_2       = run && fl && !ms;

`ifdef PC_PERF_CNT_EN
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  wire count_br = !ms && s3_q.valid && s3_q.is_branch;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (count_br && !(&branch_cnt_q)) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
    end
    if (count_br && fl && !(&mispred_cnt_q)) begin
      mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
`else
  assign bus.branch_cnt  = {CNT_W{1'b0}};
  assign bus.mispred_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_pc_pipe.sv
// Directed scenarios for fetch_pc_pipe; stage-3 retirements are checked
// against a queue of expected {PC, taken, branch} records.
module tb_fetch_pc_pipe;
  import fetch_pc_pipe_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic        tk;
    logic        br;
  } sb_entry_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  sb_entry_t sb_q[$];
  sb_entry_t mon_e;

  fetch_pc_pipe_if #(.CNT_W(32)) bus ();

  fetch_pc_pipe #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every unstalled edge retires whatever valid instruction sits in stage 3.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.valid_3 === 1'b1 && bus.memory_stall === 1'b0) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected PC_3=%h with no expected entry", bus.PC_3);
      end else begin
        mon_e = sb_q.pop_front();
        if ({bus.PC_3, bus.prev_taken_3, bus.is_branch_3} !== {mon_e.pc, mon_e.tk, mon_e.br}) begin
          errors++;
          $display("FAIL sb_stage3 got pc=%h tk=%b br=%b required pc=%h tk=%b br=%b",
                   bus.PC_3, bus.prev_taken_3, bus.is_branch_3, mon_e.pc, mon_e.tk, mon_e.br);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ms, input logic hs, input logic fl, input logic tk,
                       input logic br, input logic [31:0] bpc);
    bus.memory_stall = ms;
    bus.hazard_stall = hs;
    bus.btb_flush    = fl;
    bus.btb_taken    = tk;
    bus.is_branch_2  = br;
    bus.btb_branchPC = bpc;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic br);
    sb_q.push_back('{pc: pc, tk: tk, br: br});
  endtask

  task automatic do_reset;
    tick();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h4);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain_check(input string name);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s left=%0d required=0", name, sb_q.size());
    end
  endtask

  task automatic test_reset;
    tick();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.PC_1, bus.PC_2, bus.PC_3} !== 96'h0) begin
      errors++;
      $display("FAIL rst_pcs got=%h %h %h required=0 0 0", bus.PC_1, bus.PC_2, bus.PC_3);
    end
    checks++;
    if ({bus.fetch_valid, bus.valid_2, bus.valid_3, bus.prev_taken_3, bus.is_branch_3, bus.kill_2} !== 6'b0) begin
      errors++;
      $display("FAIL rst_flags got=%b%b%b%b%b%b required=000000", bus.fetch_valid, bus.valid_2,
               bus.valid_3, bus.prev_taken_3, bus.is_branch_3, bus.kill_2);
    end
    checks++;
    if ({bus.branch_cnt, bus.mispred_cnt} !== 64'h0) begin
      errors++;
      $display("FAIL rst_cnt got=%0d %0d required=0 0", bus.branch_cnt, bus.mispred_cnt);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({bus.fetch_valid, bus.PC_1} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL boot got fv=%b pc=%h required fv=0 pc=0", bus.fetch_valid, bus.PC_1);
    end
  endtask

  task automatic test_sequential;
    do_reset();
    checks++;
    if ({bus.fetch_valid, bus.PC_1} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL seq_boot got fv=%b pc=%h required fv=0 pc=0", bus.fetch_valid, bus.PC_1);
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if ({bus.fetch_valid, bus.PC_1} !== {1'b1, 32'(4 * (c - 1))}) begin
        errors++;
        $display("FAIL seq_pc1 cyc=%0d got fv=%b pc=%h required fv=1 pc=%h", c, bus.fetch_valid,
                 bus.PC_1, 32'(4 * (c - 1)));
      end
      checks++;
      if (bus.valid_3 !== (c >= 3)) begin
        errors++;
        $display("FAIL seq_valid3 cyc=%0d got=%b required=%b", c, bus.valid_3, (c >= 3));
      end
      if (c >= 2) begin
        checks++;
        if ({bus.valid_2, bus.PC_2} !== {1'b1, 32'(4 * (c - 2))}) begin
          errors++;
          $display("FAIL seq_stage2 cyc=%0d got v=%b pc=%h required v=1 pc=%h", c, bus.valid_2,
                   bus.PC_2, 32'(4 * (c - 2)));
        end
      end
      drive(0, 0, 0, 0, c[0], 32'(4 * c));
      if (c >= 2 && c < 6) push(32'(4 * (c - 2)), 1'b0, c[0]);
    end
    drain_check("seq");
  endtask

  task automatic test_taken;
    do_reset();
    tick(); drive(0, 0, 0, 0, 0, 32'h4);
    tick(); drive(0, 0, 0, 0, 0, 32'h8); push(32'h0, 0, 0);
    tick();
    checks++;
    if (bus.PC_1 !== 32'h8) begin
      errors++;
      $display("FAIL taken_pc1 got=%h required=00000008", bus.PC_1);
    end
    drive(0, 0, 0, 1, 0, 32'h40); push(32'h4, 0, 0);
    tick();
    checks++;
    if ({bus.PC_1, bus.PC_2, bus.valid_2} !== {32'h40, 32'h8, 1'b1}) begin
      errors++;
      $display("FAIL taken_stage2 got pc1=%h pc2=%h v2=%b required 40 08 1", bus.PC_1, bus.PC_2, bus.valid_2);
    end
    drive(0, 0, 0, 0, 1, 32'h44); push(32'h8, 1, 1);
    tick();
    checks++;
    if ({bus.PC_3, bus.prev_taken_3, bus.is_branch_3, bus.PC_1} !== {32'h8, 1'b1, 1'b1, 32'h44}) begin
      errors++;
      $display("FAIL taken_stage3 got pc3=%h tk=%b br=%b pc1=%h required 08 1 1 44", bus.PC_3,
               bus.prev_taken_3, bus.is_branch_3, bus.PC_1);
    end
    drive(0, 0, 0, 0, 0, 32'h48);
    drain_check("taken");
  endtask

  task automatic test_flush;
    do_reset();
    tick(); drive(0, 0, 0, 0, 0, 32'h4);
    tick(); drive(0, 0, 0, 0, 1, 32'h8); push(32'h0, 0, 1);
    tick(); drive(0, 0, 1, 0, 0, 32'h100);
    #1;
    checks++;
    if (bus.kill_2 !== 1'b1) begin
      errors++;
      $display("FAIL flush_kill got=%b required=1", bus.kill_2);
    end
    tick();
    drive(0, 0, 0, 0, 0, 32'h104);
    #1;
    checks++;
    if ({bus.PC_1, bus.valid_2, bus.valid_3, bus.kill_2} !== {32'h100, 3'b000}) begin
      errors++;
      $display("FAIL flush_redirect got pc1=%h v2=%b v3=%b kill=%b required 100 0 0 0", bus.PC_1,
               bus.valid_2, bus.valid_3, bus.kill_2);
    end
    tick();
    checks++;
    if ({bus.PC_1, bus.PC_2, bus.valid_2, bus.valid_3} !== {32'h104, 32'h100, 2'b10}) begin
      errors++;
      $display("FAIL flush_refill got pc1=%h pc2=%h v2=%b v3=%b required 104 100 1 0", bus.PC_1,
               bus.PC_2, bus.valid_2, bus.valid_3);
    end
    drive(0, 0, 0, 0, 0, 32'h108); push(32'h100, 0, 0);
    tick();
    checks++;
    if ({bus.valid_3, bus.PC_3} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL flush_stage3 got v3=%b pc3=%h required 1 100", bus.valid_3, bus.PC_3);
    end
    drive(0, 0, 0, 0, 0, 32'h10C);
    drain_check("flush");
  endtask

  task automatic test_mem_stall;
    do_reset();
    tick(); drive(0, 0, 0, 0, 0, 32'h4);
    tick(); drive(0, 0, 0, 0, 0, 32'h8); push(32'h0, 0, 0);
    tick(); drive(0, 0, 0, 0, 1, 32'hC); push(32'h4, 0, 1);
    tick(); drive(1, 0, 1, 0, 0, 32'h200);
    #1;
    checks++;
    if (bus.kill_2 !== 1'b0) begin
      errors++;
      $display("FAIL stall_kill got=%b required=0", bus.kill_2);
    end
    for (int c = 5; c <= 7; c++) begin
      tick();
      checks++;
      if ({bus.fetch_valid, bus.PC_1, bus.PC_3, bus.valid_3} !== {1'b0, 32'hC, 32'h4, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got fv=%b pc1=%h pc3=%h v3=%b required 0 0c 04 1", c,
                 bus.fetch_valid, bus.PC_1, bus.PC_3, bus.valid_3);
      end
      if (c == 5) drive(1, 0, 1, 0, 0, 32'h300);
      else if (c == 6) drive(1, 0, 0, 0, 0, 32'h300);
      else drive(0, 0, 0, 0, 0, 32'h999);
    end
    tick();
    checks++;
    if ({bus.PC_1, bus.fetch_valid, bus.valid_2, bus.valid_3} !== {32'h200, 3'b100}) begin
      errors++;
      $display("FAIL stall_redirect got pc1=%h fv=%b v2=%b v3=%b required 200 1 0 0", bus.PC_1,
               bus.fetch_valid, bus.valid_2, bus.valid_3);
    end
    drive(0, 0, 0, 0, 0, 32'h204);
    drain_check("stall");
  endtask

  task automatic test_hazard;
    do_reset();
    tick(); drive(0, 0, 0, 0, 0, 32'h4);
    tick(); drive(0, 0, 0, 0, 0, 32'h8); push(32'h0, 0, 0);
    tick(); drive(0, 0, 0, 0, 0, 32'hC); push(32'h4, 0, 0);
    tick(); drive(0, 1, 0, 0, 0, 32'h10);
    tick();
    checks++;
    if ({bus.PC_1, bus.PC_2, bus.valid_2, bus.valid_3} !== {32'hC, 32'h8, 2'b10}) begin
      errors++;
      $display("FAIL hazard_hold got pc1=%h pc2=%h v2=%b v3=%b required 0c 08 1 0", bus.PC_1,
               bus.PC_2, bus.valid_2, bus.valid_3);
    end
    drive(0, 0, 0, 0, 1, 32'h10); push(32'h8, 0, 1);
    tick();
    drive(0, 1, 1, 0, 0, 32'h500);
    #1;
    checks++;
    if (bus.kill_2 !== 1'b1) begin
      errors++;
      $display("FAIL hazard_flush_kill got=%b required=1", bus.kill_2);
    end
    tick();
    checks++;
    if ({bus.PC_1, bus.valid_2, bus.valid_3} !== {32'h500, 2'b00}) begin
      errors++;
      $display("FAIL hazard_flush_wins got pc1=%h v2=%b v3=%b required 500 0 0", bus.PC_1,
               bus.valid_2, bus.valid_3);
    end
    drive(0, 0, 0, 0, 0, 32'h504);
    drain_check("hazard");
  endtask

  task automatic test_reset_pend;
    do_reset();
    tick(); drive(0, 0, 0, 0, 0, 32'h4);
    tick(); drive(1, 0, 1, 0, 0, 32'h700);
    tick(); drive(1, 0, 0, 0, 0, 32'h700);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.PC_1, bus.fetch_valid, bus.valid_2} !== {32'h0, 2'b00}) begin
      errors++;
      $display("FAIL async_rst got pc1=%h fv=%b v2=%b required 0 0 0", bus.PC_1, bus.fetch_valid, bus.valid_2);
    end
    drive(0, 0, 0, 0, 0, 32'h4);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(); drive(0, 0, 0, 0, 0, 32'h4);
    tick();
    checks++;
    if ({bus.PC_1, bus.fetch_valid} !== {32'h4, 1'b1}) begin
      errors++;
      $display("FAIL pend_discard got pc1=%h fv=%b required 04 1", bus.PC_1, bus.fetch_valid);
    end
    drive(0, 0, 0, 0, 0, 32'h8);
    drain_check("rstpend");
  endtask

  logic [31:0] pc_bpc [12] = '{32'h4, 32'h8, 32'hC, 32'hC, 32'h80, 32'h84,
                               32'h88, 32'h8C, 32'hC0, 32'hC4, 32'hC8, 32'hCC};
  logic [31:0] pc_push [12] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0,
                                32'h80, 32'h84, 32'h0, 32'h0, 32'hC0, 32'h0};
  logic [11:0] ms_t   = 12'b0000_0000_0100;
  logic [11:0] hs_t   = 12'b1000_0000_0000;
  logic [11:0] fl_t   = 12'b0001_0001_0000;
  logic [11:0] push_t = 12'b0100_1100_1010;

  task automatic test_perf_cnt;
    logic [31:0] exp_b, exp_m;
`ifdef PC_PERF_CNT_EN
    exp_b = 32'd5;
    exp_m = 32'd2;
`else
    exp_b = 32'd0;
    exp_m = 32'd0;
`endif
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 4) begin
        checks++;
        if (bus.branch_cnt !== 32'd0) begin
          errors++;
          $display("FAIL cnt_during_stall got=%0d required=0", bus.branch_cnt);
        end
      end
      drive(ms_t[c-1], hs_t[c-1], fl_t[c-1], 0, 1, pc_bpc[c-1]);
      if (push_t[c-1]) push(pc_push[c-1], 0, 1);
    end
    tick();
    checks++;
    if (bus.branch_cnt !== exp_b) begin
      errors++;
      $display("FAIL branch_cnt got=%0d required=%0d", bus.branch_cnt, exp_b);
    end
    checks++;
    if (bus.mispred_cnt !== exp_m) begin
      errors++;
      $display("FAIL mispred_cnt got=%0d required=%0d", bus.mispred_cnt, exp_m);
    end
    drive(0, 0, 0, 0, 0, 32'h0);
    drain_check("perf");
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0);
    test_reset();
    test_sequential();
    test_taken();
    test_flush();
    test_mem_stall();
    test_hazard();
    test_reset_pend();
    test_perf_cnt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
